// File: rtl/ariane_irq_gateway.sv
`default_nettype none
// ============================================================================
//  Module   : ariane_irq_gateway
//  Summary  : Per-source interrupt gateway with edge/level capture, pending,
//             enable and mode registers behind a simple valid/ready config
//             bus with one-cycle registered read responses.
//  Options  : ARIANE_IRQ_GATEWAY_SYNC_EN - when defined, each irqs_in bit
//             passes a 2-flop synchroniser before it is sampled; otherwise
//             irqs_in is used directly and must already be aclk-synchronous.
//  Revision : 1.0 - initial release
// ============================================================================
module ariane_irq_gateway #(
  parameter int               N_IRQ      = 3,
  parameter logic [N_IRQ-1:0] MODE_RST   = '0,
  parameter int               ADDR_WIDTH = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [N_IRQ-1:0]      irqs_in,
  output logic [N_IRQ-1:0]      irq_out,
  output logic                  irq_any,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic                  cfg_we,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [31:0]           cfg_wdata,
  output logic                  cfg_rvalid,
  output logic [31:0]           cfg_rdata
);

  // Word indices of the register map (byte addresses 0x0, 0x4, 0x8, 0xC)
  localparam logic [1:0] c_idx_pending = 2'd0;
  localparam logic [1:0] c_idx_enable  = 2'd1;
  localparam logic [1:0] c_idx_mode    = 2'd2;
  localparam logic [1:0] c_idx_raw     = 2'd3;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } cfg_state_e;

  // --------------------------------------------------------------------------
  // Input sampling
  // --------------------------------------------------------------------------
  logic [N_IRQ-1:0] sampled;

`ifdef ARIANE_IRQ_GATEWAY_SYNC_EN
  logic [N_IRQ-1:0] sync1_d, sync1_q;
  logic [N_IRQ-1:0] sync2_d, sync2_q;

  // Two-stage shift of the asynchronous sources into the aclk domain
  always_comb begin
    sync1_d = irqs_in;
    sync2_d = sync1_q;
  end

  // Synchroniser flops
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign sampled = sync2_q;
`else
  assign sampled = irqs_in;
`endif

  // --------------------------------------------------------------------------
  // Config bus decode
  // --------------------------------------------------------------------------
  cfg_state_e       state_d, state_q;
  logic             accept;
  logic             wr_en;
  logic             rd_en;
  logic [1:0]       word_idx;
  logic             addr_hi_zero;
  logic             wr_pending;
  logic             wr_enable;
  logic             wr_mode;
  logic             unused_cfg;

  assign cfg_ready = (state_q == ST_IDLE);
  assign accept    = cfg_valid & cfg_ready;
  assign wr_en     = accept & cfg_we;
  assign rd_en     = accept & ~cfg_we;
  assign word_idx  = cfg_addr[3:2];

  // Byte-lane bits and write-data bits above N_IRQ carry no meaning here
  assign unused_cfg = ^{cfg_wdata, cfg_addr};

  // Any set address bit above the 16-byte window makes the access unmapped
  generate
    if (ADDR_WIDTH > 4) begin : g_addr_hi
      assign addr_hi_zero = (cfg_addr[ADDR_WIDTH-1:4] == '0);
    end else begin : g_addr_lo
      assign addr_hi_zero = 1'b1;
    end
  endgenerate

  assign wr_pending = wr_en & addr_hi_zero & (word_idx == c_idx_pending);
  assign wr_enable  = wr_en & addr_hi_zero & (word_idx == c_idx_enable);
  assign wr_mode    = wr_en & addr_hi_zero & (word_idx == c_idx_mode);

  // --------------------------------------------------------------------------
  // Interrupt state
  // --------------------------------------------------------------------------
  logic [N_IRQ-1:0] pending_d, pending_q;
  logic [N_IRQ-1:0] enable_d,  enable_q;
  logic [N_IRQ-1:0] mode_d,    mode_q;
  logic [N_IRQ-1:0] prev_d,    prev_q;
  logic [N_IRQ-1:0] irq_out_d, irq_out_q;
  logic             irq_any_d, irq_any_q;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] w1c;

  assign rise = sampled & ~prev_q;
  assign w1c  = wr_pending ? cfg_wdata[N_IRQ-1:0] : '0;

  // ENABLE and MODE are plain RW registers
  always_comb begin
    enable_d = enable_q;
    mode_d   = mode_q;
    if (wr_enable) begin
      enable_d = cfg_wdata[N_IRQ-1:0];
    end
    if (wr_mode) begin
      mode_d = cfg_wdata[N_IRQ-1:0];
    end
  end

  // PENDING update: mode transitions first, then level load or edge set/W1C
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < N_IRQ; i++) begin
      if (!mode_q[i] && mode_d[i]) begin
        // level -> edge: start from a clean slate
        pending_d[i] = 1'b0;
      end else if (!mode_d[i]) begin
        // level source (also covers edge -> level): track the input
        pending_d[i] = sampled[i];
      end else if (rise[i]) begin
        // a fresh edge beats a coincident W1C
        pending_d[i] = 1'b1;
      end else if (w1c[i]) begin
        pending_d[i] = 1'b0;
      end
    end
  end

  // Edge history and registered interrupt outputs
  always_comb begin
    prev_d    = sampled;
    irq_out_d = pending_q & enable_q;
    irq_any_d = |irq_out_d;
  end

  // Interrupt state flops
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pending_q <= '0;
      enable_q  <= '0;
      mode_q    <= MODE_RST;
      prev_q    <= '0;
      irq_out_q <= '0;
      irq_any_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      enable_q  <= enable_d;
      mode_q    <= mode_d;
      prev_q    <= prev_d;
      irq_out_q <= irq_out_d;
      irq_any_q <= irq_any_d;
    end
  end

  assign irq_out = irq_out_q;
  assign irq_any = irq_any_q;

  // --------------------------------------------------------------------------
  // Read path and response FSM
  // --------------------------------------------------------------------------
  logic [31:0] rd_word;
  logic        rvalid_d, rvalid_q;
  logic [31:0] rdata_d,  rdata_q;

  // Read mux over the pre-edge register state; unmapped addresses read 0
  always_comb begin
    rd_word = '0;
    if (addr_hi_zero) begin
      case (word_idx)
        c_idx_pending: rd_word[N_IRQ-1:0] = pending_q;
        c_idx_enable:  rd_word[N_IRQ-1:0] = enable_q;
        c_idx_mode:    rd_word[N_IRQ-1:0] = mode_q;
        c_idx_raw:     rd_word[N_IRQ-1:0] = sampled;
        default:       rd_word = '0;
      endcase
    end
  end

  // Accepted read moves to RESP for exactly one cycle; rdata is zero otherwise
  always_comb begin
    state_d  = state_q;
    rvalid_d = 1'b0;
    rdata_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (rd_en) begin
          state_d  = ST_RESP;
          rvalid_d = 1'b1;
          rdata_d  = rd_word;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state and registered response outputs
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign cfg_rvalid = rvalid_q;
  assign cfg_rdata  = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ariane_irq_gateway.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ariane_irq_gateway
//  Summary  : Directed self-checking bench for ariane_irq_gateway
//             (N_IRQ=3, MODE_RST=3'b101, ADDR_WIDTH=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ariane_irq_gateway;

`ifdef ARIANE_IRQ_GATEWAY_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic        aclk      = 1'b0;
  logic        aresetn   = 1'b0;
  logic [2:0]  irqs_in   = '0;
  logic [2:0]  irq_out;
  logic        irq_any;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic        cfg_we    = 1'b0;
  logic [3:0]  cfg_addr  = '0;
  logic [31:0] cfg_wdata = '0;
  logic        cfg_rvalid;
  logic [31:0] cfg_rdata;

  int checks   = 0;
  int failures = 0;

  ariane_irq_gateway #(
    .N_IRQ      (3),
    .MODE_RST   (3'b101),
    .ADDR_WIDTH (4)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .irqs_in    (irqs_in),
    .irq_out    (irq_out),
    .irq_any    (irq_any),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_rvalid (cfg_rvalid),
    .cfg_rdata  (cfg_rdata)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic cfg_write(input logic [3:0] addr, input logic [31:0] data);
    cfg_valid = 1'b1;
    cfg_we    = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = data;
    tick();
    cfg_valid = 1'b0;
    cfg_we    = 1'b0;
    cfg_wdata = '0;
  endtask

  task automatic read_expect(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    int n;
    n = 0;
    while (!cfg_ready && n < 10) begin
      tick();
      n++;
    end
    if (!cfg_ready) check({tag, "_ready_timeout"}, {31'b0, cfg_ready}, 32'd1);
    cfg_valid = 1'b1;
    cfg_we    = 1'b0;
    cfg_addr  = addr;
    tick();
    cfg_valid = 1'b0;
    check({tag, "_rvalid"}, {31'b0, cfg_rvalid}, 32'd1);
    check({tag, "_busy"},   {31'b0, cfg_ready},  32'd0);
    check(tag, cfg_rdata, exp);
    tick();
    check({tag, "_rvalid_drop"}, {31'b0, cfg_rvalid}, 32'd0);
    check({tag, "_rdata_idle"},  cfg_rdata, 32'd0);
  endtask

  initial begin
    int seen_rvalid;

    // Reset state while reset is held
    #2;
    check("rst_irq_out", {29'b0, irq_out}, 32'd0);
    check("rst_irq_any", {31'b0, irq_any}, 32'd0);
    check("rst_rvalid",  {31'b0, cfg_rvalid}, 32'd0);
    check("rst_rdata",   cfg_rdata, 32'd0);
    repeat (2) tick();
    aresetn = 1'b1;
    tick();
    check("rst_ready", {31'b0, cfg_ready}, 32'd1);

    // Reset register contents
    read_expect("rst_mode",    4'h8, 32'h5);
    read_expect("rst_enable",  4'h4, 32'h0);
    read_expect("rst_pending", 4'h0, 32'h0);
    read_expect("rst_raw",     4'hC, 32'h0);

    // Edge source 0: one-cycle pulse, latency, hold, W1C
    cfg_write(4'h8, 32'h1);
    cfg_write(4'h4, 32'h1);
    irqs_in[0] = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      if (k == 1) irqs_in[0] = 1'b0;
      if (k == LAT - 1) check("edge_lat_early", {29'b0, irq_out}, 32'h0);
    end
    check("edge_lat", {29'b0, irq_out}, 32'h1);
    repeat (3) tick();
    check("edge_hold",     {29'b0, irq_out}, 32'h1);
    check("edge_hold_any", {31'b0, irq_any}, 32'h1);
    read_expect("edge_pending", 4'h0, 32'h1);
    cfg_write(4'h0, 32'h1);
    check("w1c_out_lag", {29'b0, irq_out}, 32'h1);
    tick();
    check("w1c_out_clr", {29'b0, irq_out}, 32'h0);
    check("w1c_any_clr", {31'b0, irq_any}, 32'h0);

    // Level source 1: follow input, W1C has no effect
    cfg_write(4'h4, 32'h3);
    irqs_in[1] = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      if (k == LAT - 1) check("lvl_rise_early", {29'b0, irq_out}, 32'h0);
    end
    check("lvl_rise", {29'b0, irq_out}, 32'h2);
    cfg_write(4'h0, 32'h2);
    read_expect("lvl_w1c_pending", 4'h0, 32'h2);
    check("lvl_w1c_out", {29'b0, irq_out}, 32'h2);
    irqs_in[1] = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      if (k == LAT - 1) check("lvl_fall_early", {29'b0, irq_out}, 32'h2);
    end
    check("lvl_fall", {29'b0, irq_out}, 32'h0);

    // Edge on source 2 coincident with W1C: set wins; plain W1C clears
    cfg_write(4'h8, 32'h5);
    irqs_in[2] = 1'b1;
    repeat (LAT - 2) tick();
    cfg_write(4'h0, 32'h4);
    read_expect("coinc_pending", 4'h0, 32'h4);
    check("coinc_masked", {29'b0, irq_out}, 32'h0);
    cfg_write(4'h0, 32'h4);
    read_expect("w1c_only_pending", 4'h0, 32'h0);
    irqs_in[2] = 1'b0;
    repeat (LAT) tick();

    // Pending latches while disabled; enabling releases it next edge
    cfg_write(4'h4, 32'h0);
    irqs_in[0] = 1'b1;
    for (int k = 1; k <= LAT + 2; k++) begin
      tick();
      if (k == 1) irqs_in[0] = 1'b0;
    end
    check("dis_out", {29'b0, irq_out}, 32'h0);
    check("dis_any", {31'b0, irq_any}, 32'h0);
    read_expect("dis_pending", 4'h0, 32'h1);
    cfg_write(4'h4, 32'h1);
    check("en_out_lag", {29'b0, irq_out}, 32'h0);
    tick();
    check("en_out", {29'b0, irq_out}, 32'h1);
    check("en_any", {31'b0, irq_any}, 32'h1);

    // Mode transitions: edge->level loads sampled, level->edge clears
    cfg_write(4'h8, 32'h4);
    read_expect("e2l_pending", 4'h0, 32'h0);
    check("e2l_out", {29'b0, irq_out}, 32'h0);
    irqs_in[1] = 1'b1;
    repeat (LAT) tick();
    read_expect("l2e_pre", 4'h0, 32'h2);
    cfg_write(4'h8, 32'h6);
    read_expect("l2e_pending", 4'h0, 32'h0);
    irqs_in[1] = 1'b0;
    repeat (LAT) tick();

    // Upper bits ignored, RAW view, back-to-back writes
    cfg_write(4'h4, 32'hFFFF_FFFF);
    read_expect("enable_upper", 4'h4, 32'h7);
    irqs_in = 3'b111;
    repeat (LAT) tick();
    read_expect("raw_all", 4'hC, 32'h7);
    irqs_in = 3'b000;
    repeat (LAT) tick();
    cfg_write(4'h4, 32'h2);
    cfg_write(4'h8, 32'h3);
    read_expect("b2b_enable", 4'h4, 32'h2);
    read_expect("b2b_mode",   4'h8, 32'h3);

    // Reset asserted during RESP aborts the response
    cfg_valid = 1'b1;
    cfg_we    = 1'b0;
    cfg_addr  = 4'h8;
    tick();
    cfg_valid = 1'b0;
    check("abort_resp_started", {31'b0, cfg_rvalid}, 32'd1);
    aresetn = 1'b0;
    #1;
    check("abort_rvalid", {31'b0, cfg_rvalid}, 32'd0);
    check("abort_rdata",  cfg_rdata, 32'd0);
    repeat (2) tick();
    aresetn = 1'b1;
    seen_rvalid = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (cfg_rvalid) seen_rvalid++;
    end
    check("abort_no_pulse", seen_rvalid, 32'd0);
    read_expect("abort_mode",   4'h8, 32'h5);
    read_expect("abort_enable", 4'h4, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
